// File: rtl/timer_arbiter_pkg.sv
// Shared Timer bus constants, control words and FSM state encodings for timer_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_arbiter_pkg;

    // Bus direction encodings and existing Timer register map.
    localparam logic       BUS_READ             = 1'b1;
    localparam logic       BUS_WRITE            = 1'b0;
    localparam logic [2:0] TIMER_CTRL_ADDR      = 3'h0;
    localparam logic [2:0] TIMER_EXPR_ADDR      = 3'h2;
    localparam logic [1:0] TIMER_MODE_SINGLE_UP = 2'b01;

    // CTRL words: bit 2 is start, bits 1:0 the counting mode.
    localparam logic [31:0] TARB_CTRL_START = {29'b0, 1'b1, TIMER_MODE_SINGLE_UP};
    localparam logic [31:0] TARB_CTRL_STOP  = {29'b0, 1'b0, TIMER_MODE_SINGLE_UP};

    typedef enum logic [3:0] {
        TARB_ST_IDLE,
        TARB_ST_WR_EXPR,
        TARB_ST_WAIT_EXPR,
        TARB_ST_WR_CTRL,
        TARB_ST_WAIT_CTRL,
        TARB_ST_RUN,
        TARB_ST_WR_STOP,
        TARB_ST_WAIT_STOP,
        TARB_ST_DONE
    } tarb_state_e;

    // States that drive a write cycle on the Timer bus.
    function automatic logic tarb_is_wr(input tarb_state_e s);
        return (s == TARB_ST_WR_EXPR) || (s == TARB_ST_WR_CTRL) || (s == TARB_ST_WR_STOP);
    endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Timer slave bus: one-cycle cs/as write strobes, registered rdy, expiry irq.
// Latency: rdy follows cs&as by one cycle (Timer side).
// Backpressure: master holds off the next access until rdy is seen.
interface timer_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          tmr_cs;
    logic          tmr_as;
    logic          tmr_rw;
    logic [AW-1:0] tmr_addr;
    logic [DW-1:0] tmr_wr_data;
    logic          tmr_rdy;
    logic          tmr_irq;

    modport master (
        output tmr_cs, tmr_as, tmr_rw, tmr_addr, tmr_wr_data,
        input  tmr_rdy, tmr_irq
    );

    modport slave (
        input  tmr_cs, tmr_as, tmr_rw, tmr_addr, tmr_wr_data,
        output tmr_rdy, tmr_irq
    );
endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping upward.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on vld/idx.
module timer_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,   // pending request levels
    input  logic [IW-1:0] ptr,   // highest-priority position this round
    output logic          vld,   // at least one request pending
    output logic [IW-1:0] idx    // chosen requester
);
    int            c;
    logic [IW-1:0] cand;

    always_comb begin
        vld  = |req;
        idx  = '0;
        c    = 0;
        cand = '0;
        // Walk offsets from farthest to nearest so the nearest set bit wins.
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            cand = IW'(c);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/timer_arbiter.sv
// Shares one Timer among N_REQ requesters: round-robin grant, program EXPR/CTRL, wait irq, stop, pulse done.
// Latency: grant 1 cycle after req; each bus write 2 cycles with rdy at +1; done 1 cycle after the stop write.
// Backpressure: waits indefinitely on tmr_rdy; other requests stay pending by level until the next IDLE.
// Ports: clk/rest (async active-low); req/req_delay in; gnt/done one-hot out; busy; tmr = Timer bus master.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rest,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_delay,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    timer_arbiter_if.master     tmr
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tarb_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, ptr_adv;
    logic [DW-1:0]    dly_q, dly_d, data_q, data_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             busy_q, busy_d, cs_q, cs_d, rw_q, rw_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             cmpl_q, cmpl_d;   // irq seen: finish via DONE rather than IDLE
    logic             cxl_q, cxl_d;     // request withdrawn during the EXPR write
    logic             pick_vld, req_held;
    logic [IW-1:0]    pick_idx;
    logic [DW-1:0]    dly_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_dly
        assign dly_arr[g] = req_delay[g*DW +: DW];
    end

    timer_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign req_held = req[idx_q];
    assign ptr_adv  = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        cmpl_d  = cmpl_q;
        cxl_d   = cxl_q;
        unique case (state_q)
            TARB_ST_IDLE: begin
                // A gnt left over from DONE drops here, together with done.
                gnt_d = '0;
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    dly_d   = dly_arr[pick_idx];
                    gnt_d   = N_REQ'(1) << pick_idx;
                    cmpl_d  = 1'b0;
                    cxl_d   = 1'b0;
                    state_d = (dly_arr[pick_idx] == '0) ? TARB_ST_DONE : TARB_ST_WR_EXPR;
                end
            end
            TARB_ST_WR_EXPR: begin
                if (!req_held) cxl_d = 1'b1;
                state_d = TARB_ST_WAIT_EXPR;
            end
            TARB_ST_WAIT_EXPR: begin
                if (tmr.tmr_rdy) begin
                    if (cxl_q || !req_held) begin
                        // Withdrawn before start: the Timer was never started, nothing to stop.
                        gnt_d   = '0;
                        ptr_d   = ptr_adv;
                        state_d = TARB_ST_IDLE;
                    end else begin
                        state_d = TARB_ST_WR_CTRL;
                    end
                end else if (!req_held) begin
                    cxl_d = 1'b1;
                end
            end
            TARB_ST_WR_CTRL: state_d = TARB_ST_WAIT_CTRL;
            TARB_ST_WAIT_CTRL: begin
                if (!req_held) begin
                    cmpl_d  = 1'b0;
                    state_d = TARB_ST_WR_STOP;
                end else if (tmr.tmr_rdy) begin
                    state_d = TARB_ST_RUN;
                end
            end
            TARB_ST_RUN: begin
                // Expiry takes precedence over a same-cycle withdrawal.
                if (tmr.tmr_irq) begin
                    cmpl_d  = 1'b1;
                    state_d = TARB_ST_WR_STOP;
                end else if (!req_held) begin
                    cmpl_d  = 1'b0;
                    state_d = TARB_ST_WR_STOP;
                end
            end
            TARB_ST_WR_STOP: state_d = TARB_ST_WAIT_STOP;
            TARB_ST_WAIT_STOP: begin
                if (tmr.tmr_rdy) begin
                    if (cmpl_q) begin
                        state_d = TARB_ST_DONE;
                    end else begin
                        gnt_d   = '0;
                        ptr_d   = ptr_adv;
                        state_d = TARB_ST_IDLE;
                    end
                end
            end
            TARB_ST_DONE: begin
                done_d  = gnt_q;
                ptr_d   = ptr_adv;
                state_d = TARB_ST_IDLE;
            end
            default: state_d = TARB_ST_IDLE;
        endcase
    end

    // Bus outputs are registered copies of what the next state needs.
    always_comb begin
        cs_d   = tarb_is_wr(state_d);
        rw_d   = cs_d ? BUS_WRITE : BUS_READ;
        addr_d = '0;
        data_d = '0;
        busy_d = (state_d != TARB_ST_IDLE);
        unique case (state_d)
            TARB_ST_WR_EXPR: begin
                addr_d = AW'(TIMER_EXPR_ADDR);
                data_d = dly_d;
            end
            TARB_ST_WR_CTRL: begin
                addr_d = AW'(TIMER_CTRL_ADDR);
                data_d = DW'(TARB_CTRL_START);
            end
            TARB_ST_WR_STOP: begin
                addr_d = AW'(TIMER_CTRL_ADDR);
                data_d = DW'(TARB_CTRL_STOP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= TARB_ST_IDLE;
            idx_q   <= '0;
            dly_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            cmpl_q  <= 1'b0;
            cxl_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
            rw_q    <= BUS_READ;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            cmpl_q  <= cmpl_d;
            cxl_q   <= cxl_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign tmr.tmr_cs      = cs_q;
    assign tmr.tmr_as      = cs_q;
    assign tmr.tmr_rw      = rw_q;
    assign tmr.tmr_addr    = addr_q;
    assign tmr.tmr_wr_data = data_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: Timer slave model, directed and random requests, reference service model.
// Latency: n/a.
// Backpressure: Timer model answers rdy one cycle after each access.
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam logic [2:0]  A_CTRL = 3'd0;
    localparam logic [2:0]  A_EXPR = 3'd2;
    localparam logic [31:0] W_START = 32'h5;
    localparam logic [31:0] W_STOP  = 32'h1;

    logic              clk = 1'b0;
    logic              rest;
    logic [N-1:0]      req, gnt, done;
    logic [N*DW-1:0]   req_delay;
    logic              busy;

    timer_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    timer_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rest      (rest),
        .req       (req),
        .req_delay (req_delay),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .tmr       (bus)
    );

    always #5 clk = ~clk;

    // Timer model: EXPR/CTRL registers, up-counter, one-cycle irq once count reaches EXPR.
    logic        t_rdy, t_irq, t_start;
    logic [31:0] t_expr, t_cnt;
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            t_rdy <= 1'b0; t_irq <= 1'b0; t_start <= 1'b0; t_expr <= '0; t_cnt <= '0;
        end else begin
            t_rdy <= bus.tmr_cs & bus.tmr_as;
            t_irq <= 1'b0;
            if (bus.tmr_cs && bus.tmr_as && bus.tmr_rw == 1'b0) begin
                if (bus.tmr_addr == A_EXPR) t_expr <= bus.tmr_wr_data;
                if (bus.tmr_addr == A_CTRL) begin
                    t_start <= bus.tmr_wr_data[2];
                    t_cnt   <= '0;
                end
            end else if (t_start) begin
                if (t_cnt >= t_expr) begin
                    t_irq   <= 1'b1;
                    t_start <= 1'b0;
                end else begin
                    t_cnt <= t_cnt + 1;
                end
            end
        end
    end
    assign bus.tmr_rdy = t_rdy;
    assign bus.tmr_irq = t_irq;

    int          total = 0;
    int          bad   = 0;
    int          oh_err = 0;
    int          cs_cnt = 0;
    logic [35:0] wr_log[$];
    int          done_log[$];
    logic [35:0] exp_wr[$];
    int          exp_done[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] wr(input logic [2:0] a, input logic [31:0] d);
        return {1'b0, a, d};
    endfunction

    // One clock; samples and logs DUT activity at the falling edge.
    task automatic step();
        @(negedge clk);
        if ($countones(gnt) > 1 || $countones(done) > 1) oh_err++;
        if (bus.tmr_cs) cs_cnt++;
        if (bus.tmr_cs && bus.tmr_as) wr_log.push_back({bus.tmr_rw, bus.tmr_addr, bus.tmr_wr_data});
        for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
    endtask

    task automatic clear_logs();
        wr_log.delete(); done_log.delete(); exp_wr.delete(); exp_done.delete(); cs_cnt = 0;
    endtask

    task automatic do_reset();
        rest = 1'b0; req = '0; step(); step(); rest = 1'b1; clear_logs();
    endtask

    task automatic set_dly(input int i, input logic [31:0] d);
        req_delay[i*DW +: DW] = d;
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int c = 0;
        while (done_log.size() < n && c < budget) begin step(); c++; end
        chk(tag, 64'(done_log.size() >= n), 64'(1));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while ((busy || gnt != '0) && c < budget) begin step(); c++; end
        chk(tag, 64'({busy, gnt}), 64'(0));
    endtask

    // Expected service: one EXPR/START/STOP triple per nonzero-delay grant.
    task automatic exp_service(input int idx, input logic [31:0] d);
        exp_done.push_back(idx);
        if (d != 0) begin
            exp_wr.push_back(wr(A_EXPR, d));
            exp_wr.push_back(wr(A_CTRL, W_START));
            exp_wr.push_back(wr(A_CTRL, W_STOP));
        end
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size(); k++)
            if (k < wr_log.size()) chk($sformatf("%s_wr%0d", tag, k), 64'(wr_log[k]), 64'(exp_wr[k]));
        chk({tag, "_ndone"}, 64'(done_log.size()), 64'(exp_done.size()));
        for (int k = 0; k < exp_done.size(); k++)
            if (k < done_log.size()) chk($sformatf("%s_done%0d", tag, k), 64'(done_log[k]), 64'(exp_done[k]));
    endtask

    // Round-robin rule: first requester at or after ptr, searching upward with wrap.
    function automatic int rr_next(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    initial begin
        int          c;
        int          g_err;
        int          ptr;
        int          idx;
        logic [N-1:0] mask;
        logic [31:0]  d [N];

        rest = 1'b0; req = '0; req_delay = '0;
        step(); step();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_bus", 64'({bus.tmr_cs, bus.tmr_as, bus.tmr_rw, bus.tmr_addr, bus.tmr_wr_data}),
            64'({1'b0, 1'b0, 1'b1, 3'd0, 32'd0}));
        rest = 1'b1; clear_logs(); step();

        // Single request, delay 5.
        set_dly(0, 5); req = 4'b0001;
        step();
        chk("s1_gnt_first", 64'(gnt), 64'(4'b0001));
        chk("s1_busy", 64'(busy), 64'(1));
        c = 0; g_err = 0;
        while (done_log.size() == 0 && c < 80) begin
            if (gnt != 4'b0001) g_err++;
            step(); c++;
        end
        req = '0;
        chk("s1_gnt_held", 64'(g_err), 64'(0));
        chk("s1_done_gnt_together", 64'({gnt, done}), 64'({4'b0001, 4'b0001}));
        step();
        chk("s1_drop", 64'({gnt, done}), 64'(0));
        step(); step();
        chk("s1_busy_after", 64'(busy), 64'(0));
        exp_service(0, 5);
        cmp_logs("s1");

        // All four requesting, delay 3: five services in round-robin order.
        do_reset();
        for (int i = 0; i < N; i++) set_dly(i, 3);
        req = 4'b1111;
        wait_dones(5, 300, "s2_five_dones");
        req = '0;
        ptr = 0;
        for (int k = 0; k < 5; k++) begin
            idx = rr_next(4'b1111, ptr);
            exp_service(idx, 3);
            ptr = (idx + 1) % N;
        end
        wait_idle(20, "s2_idle");
        cmp_logs("s2");

        // Zero delay: no bus traffic, done two cycles after req.
        do_reset();
        set_dly(2, 0); req = 4'b0100;
        step();
        chk("s3_gnt", 64'({gnt, done}), 64'({4'b0100, 4'b0000}));
        step();
        chk("s3_done", 64'(done), 64'(4'b0100));
        req = '0;
        step();
        chk("s3_drop", 64'({gnt, done}), 64'(0));
        chk("s3_no_cs", 64'(cs_cnt), 64'(0));

        // Withdrawal during RUN: stop issued, no done, next grant goes past the cancelled index.
        do_reset();
        set_dly(1, 100); set_dly(0, 2); set_dly(3, 2);
        req = 4'b0010;
        c = 0;
        while (wr_log.size() < 2 && c < 30) begin step(); c++; end
        chk("s4_ctrl_seen", 64'(wr_log.size() >= 2), 64'(1));
        repeat (11) step();
        req = 4'b1001;
        c = 0;
        while ((gnt == '0 || gnt == 4'b0010) && c < 40) begin step(); c++; end
        chk("s4_next_gnt", 64'(gnt), 64'(4'b1000));
        chk("s4_no_done", 64'(done_log.size()), 64'(0));
        exp_wr.push_back(wr(A_EXPR, 100));
        exp_wr.push_back(wr(A_CTRL, W_START));
        exp_wr.push_back(wr(A_CTRL, W_STOP));
        exp_wr.push_back(wr(A_EXPR, 2));
        cmp_logs("s4");
        req = '0;
        wait_idle(20, "s4_idle");

        // Withdrawal in the same cycle as irq: completion still reported.
        do_reset();
        set_dly(0, 4); req = 4'b0001;
        c = 0;
        while (!bus.tmr_irq && c < 40) begin step(); c++; end
        chk("s5_irq_seen", 64'(bus.tmr_irq), 64'(1));
        req = '0;
        c = 0;
        while (done_log.size() == 0 && c < 10) begin step(); c++; end
        exp_service(0, 4);
        cmp_logs("s5");
        wait_idle(10, "s5_idle");

        // Asynchronous reset while waiting on the CTRL write.
        do_reset();
        set_dly(1, 50); req = 4'b0010;
        c = 0;
        while (wr_log.size() < 2 && c < 30) begin step(); c++; end
        step();
        chk("s6_busy_before", 64'({busy, gnt}), 64'({1'b1, 4'b0010}));
        #2 rest = 1'b0;
        #1;
        chk("s6_async", 64'({gnt, busy, bus.tmr_cs, bus.tmr_as}), 64'(0));
        req = '0;
        step();
        rest = 1'b1; clear_logs();
        set_dly(3, 2); req = 4'b1000;
        wait_dones(1, 60, "s6_done_after");
        req = '0;
        exp_service(3, 2);
        cmp_logs("s6");
        wait_idle(10, "s6_idle");

        // Random masks and delays against the round-robin service model.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                d[i] = 32'($urandom_range(0, 6));
                set_dly(i, d[i]);
            end
            req = mask;
            wait_dones(6, 600, $sformatf("r%0d_dones", it));
            req = '0;
            ptr = 0;
            for (int k = 0; k < 6; k++) begin
                idx = rr_next(mask, ptr);
                exp_service(idx, d[idx]);
                ptr = (idx + 1) % N;
            end
            wait_idle(20, $sformatf("r%0d_idle", it));
            cmp_logs($sformatf("r%0d", it));
        end

        chk("onehot", 64'(oh_err), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Bus-master controller that shares the single Timer peripheral between N_REQ hardware requesters, each needing a one-shot delay.
- Arbitrates pending requests round-robin.
- Programs the Timer over its slave bus interface (EXPR value, then CTRL start in single-up mode).
- Waits for the Timer interrupt, stops the Timer, then pulses done to the granted requester.
- Sits between requesting blocks (e.g. UART/GPIO timeouts) and the Timer's bus port; it is the Timer's only master.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 32, data/delay width; matches `WORD_DATA
AW, 3, Timer register address width

Ports:
clk  in  1  system clock
rest  in  1  asynchronous reset, active-low
req  in  N_REQ  per-requester level request; hold high until done or to cancel
req_delay  in  N_REQ*DW  per-requester delay in timer ticks; slice i = [i*DW +: DW]; sampled at grant
gnt  out  N_REQ  one-hot, high while requester is being served
done  out  N_REQ  one-cycle pulse on completion
busy  out  1  high in any state other than IDLE
tmr_cs  out  1  Timer chip select
tmr_as  out  1  Timer address strobe
tmr_rw  out  1  `READ/`WRITE; this block only writes
tmr_addr  out  AW  Timer register address
tmr_wr_data  out  DW  Timer write data
tmr_rdy  in  1  Timer ready; registered, asserted the cycle after cs&as
tmr_irq  in  1  Timer expiry interrupt

Behaviour:
- Reset (rest=0, async): state=IDLE; gnt=0; done=0; busy=0; tmr_cs=0; tmr_as=0; tmr_rw=`READ; tmr_addr=0; tmr_wr_data=0; rr_ptr=0. All outputs are registered.
- Bus write protocol:
  - cs, as, rw=`WRITE, addr and data asserted for exactly one cycle (the WR_* state).
  - Bus then returns to idle (cs=as=0, rw=`READ), and the block waits in WAIT_* for tmr_rdy=1.
  - No overlapping transactions. No timeout: a stuck rdy hangs the block by design.
- FSM states: IDLE, WR_EXPR, WAIT_EXPR, WR_CTRL, WAIT_CTRL, RUN, WR_STOP, WAIT_STOP, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after rr_ptr, searching upward with wrap.
  - Latch index and delay, set that gnt bit, go to WR_EXPR.
  - If the latched delay is 0, go directly to DONE instead; no bus traffic.
- WR_EXPR: addr=`TIMER_EXPR_ADDR, data=delay -> WAIT_EXPR.
- WAIT_EXPR: on rdy -> WR_CTRL.
- WR_CTRL: addr=`TIMER_CTRL_ADDR, data=TARB_CTRL_START (start=1, mode=`TIMER_MODE_SINGLE_UP) -> WAIT_CTRL.
- WAIT_CTRL: on rdy -> RUN.
- RUN: on tmr_irq=1 -> WR_STOP with a completion flag set.
- WR_STOP: addr=`TIMER_CTRL_ADDR, data=TARB_CTRL_STOP (start=0) -> WAIT_STOP.
- WAIT_STOP: on rdy -> DONE if the completion flag is set, else IDLE.
- DONE: pulse done[idx] for one cycle, clear gnt, set rr_ptr=idx+1 (mod N_REQ) -> IDLE.
- Cancel: req[idx] falling while gnt is held.
  - In WAIT_CTRL or RUN: go to WR_STOP with the completion flag clear; no done pulse.
  - In WR_EXPR or WAIT_EXPR: complete the EXPR write, then go to IDLE; no start is issued.
  - rr_ptr still advances to idx+1.
- tmr_irq in the same cycle as a cancel: irq wins; done is pulsed.
- tmr_irq outside RUN: ignored.
- New req bits asserting while busy: queued by level only; considered at the next IDLE.
- gnt and done are never asserted for more than one requester.
- done[idx] and gnt[idx] drop in the same cycle, the cycle after DONE.
- Minimum latency, request to done, with delay=D≥1 and Timer rdy at +1 cycle:
  - Grant 1 cycle after req.
  - EXPR write 2 cycles.
  - CTRL write 2 cycles.
  - Irq roughly D+1 cycles later.
  - Stop write 2 cycles.
  - DONE 1 cycle.
- Reset mid-operation: all outputs return to reset values immediately. The Timer is not explicitly stopped; the system reset covers the Timer too.

Decomposition:
- Shared package/global header additions:
  - `TIMER_EXPR_ADDR, `TIMER_CTRL_ADDR, `TIMER_MODE_SINGLE_UP (existing timer constants, reused).
  - TARB_CTRL_START = {29'b0,1'b1,`TIMER_MODE_SINGLE_UP}.
  - TARB_CTRL_STOP = {29'b0,1'b0,`TIMER_MODE_SINGLE_UP}.
  - FSM state encodings TARB_ST_*.
- One sub-module: rr_pick (combinational round-robin priority picker: req, rr_ptr -> valid, idx). It is reusable by other arbiters.

Test Plan:
- Single request: req[0]=1, delay=5 -> bus writes EXPR=5 then CTRL=START; after irq, CTRL=STOP; done[0] pulses once; gnt[0] high throughout; busy low afterwards.
- Round-robin: req=4'b1111 held, all delays=3 -> service order 0,1,2,3,0; exactly one done per service; gnt always one-hot.
- Zero delay: req[2]=1, delay=0 -> no tmr_cs activity; done[2] pulses 2 cycles after req.
- Cancel in RUN: req[1]=1, delay=100; drop req[1] 10 cycles into RUN -> STOP write issued; no done; next grant goes to requester 2 or higher.
- Irq with simultaneous cancel: drop req[0] in the cycle tmr_irq=1 -> done[0] pulses.
- Async reset: assert rest=0 mid-WAIT_CTRL with no clock edge -> gnt, busy, tmr_cs and tmr_as go 0 immediately; after release, a fresh req[3] is served normally.
